// File: rtl/mips_cpu_muldiv_if.sv
// ============================================================================
// Module  : mips_cpu_muldiv_if
// Brief   : Decode-to-multiply/divide bundle: launch, MTHI/MTLO writes, HI/LO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mips_cpu_muldiv_if #(
    parameter int W = 32
);
    logic         clk_enable;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         hi_write;
    logic         lo_write;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output clk_enable, start, op, op_a, op_b, hi_write, lo_write, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  clk_enable, start, op, op_a, op_b, hi_write, lo_write, wr_data,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
// ============================================================================
// Module  : mips_cpu_muldiv
// Brief   : Iterative shift/add multiplier and restoring divider owning HI/LO.
//           Optional MULDIV_EARLY_TERM_EN: multiply stops once multiplier is 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_muldiv #(
    parameter int ITER_BITS = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mips_cpu_muldiv_if.slave      bus
);
    localparam int W  = ITER_BITS;
    localparam int CW = $clog2(ITER_BITS);
    localparam logic [CW-1:0] c_last_iter = CW'(ITER_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [CW-1:0]   r_count;
    // Multiply: r_acc = product. Divide: r_acc = {remainder, dividend/quotient}.
    logic [2*W-1:0]  r_acc;
    logic [2*W-1:0]  r_mcand;
    logic [W-1:0]    r_mplier;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_done;

    logic            w_wr;
    logic            w_signed;
    logic            w_div0;
    logic [W-1:0]    w_abs_a;
    logic [W-1:0]    w_abs_b;
    logic [W-1:0]    w_mplier_sh;
    logic [2*W-1:0]  w_mul_acc;
    logic [W:0]      w_rem_sh;
    logic [W:0]      w_rem_sub;
    logic [2*W-1:0]  w_div_acc;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_quot;
    logic [W-1:0]    w_rem;

    assign w_wr     = bus.hi_write | bus.lo_write;
    assign w_signed = ~bus.op[0];
    assign w_div0   = bus.op[1] && (bus.op_b == '0);
    // Negating 0x80000000 yields itself, which read unsigned is the 2^31 magnitude.
    assign w_abs_a  = (w_signed && bus.op_a[W-1]) ? -bus.op_a : bus.op_a;
    assign w_abs_b  = (w_signed && bus.op_b[W-1]) ? -bus.op_b : bus.op_b;

    assign w_mplier_sh = r_mplier >> 1;
    assign w_mul_acc   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    // Shifted remainder keeps its carry-out bit so divisors >= 2^31 compare correctly.
    assign w_rem_sh  = r_acc[2*W-1:W-1];
    assign w_rem_sub = w_rem_sh - {1'b0, r_mcand[W-1:0]};
    assign w_div_acc = (w_rem_sh >= {1'b0, r_mcand[W-1:0]})
                     ? {w_rem_sub[W-1:0], r_acc[W-2:0], 1'b1}
                     : {r_acc[2*W-2:0], 1'b0};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else if (bus.clk_enable) r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_wr) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_next = S_CALC;
                        if (w_div0) w_next = S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
                        if (!bus.op[1] && bus.op_b == '0) w_next = S_FIX;
`endif
                    end
                end
                S_CALC: begin
                    if (r_count == c_last_iter) w_next = S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
                    if (!r_is_div && w_mplier_sh == '0) w_next = S_FIX;
`endif
                end
                S_FIX:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            // done is a single-clock pulse even when the following edges are disabled
            r_done <= 1'b0;
            if (bus.clk_enable) begin
                if (w_wr) begin
                    if (bus.hi_write) r_hi <= bus.wr_data;
                    if (bus.lo_write) r_lo <= bus.wr_data;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (bus.start) begin
                                r_is_div <= bus.op[1];
                                r_count  <= '0;
                                r_neg_q  <= w_signed & ~w_div0 & (bus.op_a[W-1] ^ bus.op_b[W-1]);
                                r_neg_r  <= w_signed & ~w_div0 & bus.op[1] & bus.op_a[W-1];
                                r_mcand  <= {{W{1'b0}}, (bus.op[1] ? w_abs_b : w_abs_a)};
                                r_mplier <= w_abs_b;
                                if (w_div0)         r_acc <= {bus.op_a, {W{1'b1}}};
                                else if (bus.op[1]) r_acc <= {{W{1'b0}}, w_abs_a};
                                else                r_acc <= '0;
                            end
                        end
                        S_CALC: begin
                            r_count <= r_count + CW'(1);
                            if (r_is_div) begin
                                r_acc <= w_div_acc;
                            end else begin
                                r_acc    <= w_mul_acc;
                                r_mcand  <= r_mcand << 1;
                                r_mplier <= w_mplier_sh;
                            end
                        end
                        S_FIX: begin
                            r_hi   <= r_is_div ? w_rem  : w_prod[2*W-1:W];
                            r_lo   <= r_is_div ? w_quot : w_prod[W-1:0];
                            r_done <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
// ============================================================================
// Module  : tb_mips_cpu_muldiv
// Brief   : Directed self-checking bench for mips_cpu_muldiv (HI/LO, latency).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_muldiv;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    mips_cpu_muldiv_if #(.W(32)) bus ();

    mips_cpu_muldiv #(.ITER_BITS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULDIV_EARLY_TERM_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to done; stall_at > 0 drops clk_enable
    // for the 5 edges following that edge number.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int stall_at);
        int lat;
        bit busy_bad;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        busy_bad = 1'b0;
        for (int n = 0; n <= 200; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (stall_at > 0 && n == stall_at)     bus.clk_enable = 1'b0;
            if (stall_at > 0 && n == stall_at + 5) bus.clk_enable = 1'b1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (!bus.busy) busy_bad = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bit saw_done;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        bus.clk_enable = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.op_a = '0; bus.op_b = '0;
        bus.hi_write = 1'b0; bus.lo_write = 1'b0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_hi",   64'(bus.hi),   64'd0);
        check("reset_lo",   64'(bus.lo),   64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5, c_early ? 4 : 33, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
        run_op("mult_min",  2'b00, 32'h80000000, 32'd2, c_early ? 3 : 33, 32'hFFFFFFFF, 32'h00000000, 0);
        run_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0);
        run_op("divu_bigdiv", 2'b11, 32'hFFFFFFFF, 32'h80000001, 33, 32'h7FFFFFFE, 32'd1, 0);
        run_op("divu_zero", 2'b11, 32'h00001234, 32'd0, 1, 32'h00001234, 32'hFFFFFFFF, 0);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000, 0);
        run_op("multu_early", 2'b01, 32'h10, 32'd3, c_early ? 3 : 33, 32'd0, 32'h30, 0);
        run_op("multu_stall", 2'b01, 32'h1000, 32'h80000001, 38, 32'h00000800, 32'h00001000, 10);

        // MTHI and MTLO together in IDLE
        @(negedge clk);
        bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wr_data = 32'h11112222;
        @(negedge clk);
        bus.hi_write = 1'b0; bus.lo_write = 1'b0;
        check("mt_both_hi", 64'(bus.hi), 64'h11112222);
        check("mt_both_lo", 64'(bus.lo), 64'h11112222);

        // Abort a multiply with MTHI at edge 10; a start pulse while busy is ignored
        saw_done = 1'b0;
        bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd7; bus.op_b = 32'hFFFF0000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 5) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.op_a = 32'd5; bus.op_b = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            if (n == 10) begin
                bus.hi_write = 1'b1; bus.wr_data = 32'hCAFEBABE;
            end
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
            if (n == 9) check("abort_busy_before", 64'(bus.busy), 64'd1);
        end
        bus.hi_write = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi",   64'(bus.hi),   64'hCAFEBABE);
        check("abort_lo",   64'(bus.lo),   64'h11112222);
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_idle",    64'(bus.busy), 64'd0);

        // Write wins over a simultaneous start in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd3; bus.op_b = 32'd3;
        bus.lo_write = 1'b1; bus.wr_data = 32'h0BADF00D;
        @(negedge clk);
        bus.start = 1'b0; bus.lo_write = 1'b0;
        check("wr_start_busy", 64'(bus.busy), 64'd0);
        check("wr_start_lo",   64'(bus.lo),   64'h0BADF00D);
        check("wr_start_hi",   64'(bus.hi),   64'hCAFEBABE);

        // Asynchronous reset mid-CALC
        saw_done = 1'b0;
        bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("rst_pre_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_async_busy", 64'(bus.busy), 64'd0);
        check("rst_async_hi",   64'(bus.hi),   64'd0);
        check("rst_async_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("rst_no_done", 64'(saw_done), 64'd0);
        check("rst_idle",    64'(bus.busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected completion");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/mips_cpu_muldiv.md
Name: mips_cpu_muldiv

Overview:
- Iterative multiply/divide unit; owns the HI/LO architectural registers for the Harvard MIPS core.
- Decode launches MULT/MULTU/DIV/DIVU with the Rs/Rt operands and drives MTHI/MTLO writes.
- MFHI/MFLO read hi/lo directly. busy tells the core to stall.
- One-bit-per-cycle shift/add multiply and restoring divide; no combinational 64-bit multiplier or divider.

Parameters:
- ITER_BITS, 32, operand width and iteration count (fixed at 32 for MIPS32; the parameter exists only for the bench).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- clk_enable  input  1  when 0, all state holds (same meaning as core clk_enable).
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  input  32  Rs (multiplicand or dividend).
- op_b  input  32  Rt (multiplier or divisor).
- hi_write  input  1  MTHI.
- lo_write  input  1  MTLO.
- wr_data  input  32  Rs value for MTHI/MTLO.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; hi/lo were updated on this edge.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, async): state=IDLE; hi=0, lo=0, busy=0, done=0; internal accumulators and counter cleared. Reset mid-operation discards the operation; no done pulse.
- States: IDLE, CALC, FIX. All transitions occur only on edges where clk_enable=1.
- IDLE:
  - With start=1, latch the op and the operand magnitudes. For signed ops, take the two's-complement absolute value; 0x80000000 is treated as unsigned 2^31.
  - Latch result-sign flags. Set counter=0. Go to CALC; busy=1 from that edge.
- Divide by zero (op_b=0, DIV or DIVU):
  - Go directly to FIX and skip CALC.
  - Result: hi=op_a unmodified, lo=0xFFFFFFFF.
- CALC, multiply: each edge, if mplier[0] then prod += mcand (64-bit); then mcand <<= 1 and mplier >>= 1. counter++.
- CALC, divide (restoring): each edge:
  - rem = {rem[30:0], dvd[31]}; dvd <<= 1.
  - If rem >= divisor, subtract and shift in quotient bit 1; else shift in 0. counter++.
- CALC exit: go to FIX on the edge where counter reaches 31, i.e. after exactly 32 iterations.
- FIX:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo: mult gives hi=prod[63:32], lo=prod[31:0]; div gives lo=quotient, hi=remainder.
  - done=1 for that cycle, busy=0, return to IDLE.
- Latency: start sampled at edge E0 gives results and done at E33 (E1 for divide by zero). busy is high for E0..E33-exclusive.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap), no trap.
- start while busy: ignored. The core must hold it until busy=0.
- hi_write/lo_write, IDLE: write the selected register on the edge; both may be asserted in the same cycle.
- hi_write/lo_write while busy: abort the operation. Return to IDLE, perform the write, no done pulse, the other register is unchanged.
- hi_write/lo_write together with start in IDLE: the write wins and start is ignored.
- clk_enable=0: state, counter, hi, lo held. done is not re-pulsed; a pending done waits for the next enabled edge.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- Defined: in multiply CALC, if mplier becomes 0 after an iteration, go to FIX on the next edge. Latency = (index of highest set bit of |op_b|) + 2 edges; an operand op_b=0 goes straight to FIX from IDLE. Divide is unaffected.
- Undefined: fixed 32 iterations for all ops; latency exactly 33 edges (divide by zero still 1).

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 enabled edges after start; busy high throughout.
- MULT −3 × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 0x1234 / 0 -> done at E1; hi=0x00001234, lo=0xFFFFFFFF. DIV 0x80000000 / −1 -> lo=0x80000000, hi=0.
- Start MULT, then at edge 10 assert hi_write with 0xCAFEBABE -> busy drops, no done, hi=0xCAFEBABE, lo unchanged. A second start while busy is ignored.
- clk_enable held 0 for 5 cycles mid-CALC -> done delayed by exactly 5 cycles, results correct. Reset low mid-CALC -> hi=lo=0, busy=0 immediately (async), no done.
- With MULDIV_EARLY_TERM_EN: MULTU 0x10 × 3 -> hi=0, lo=0x30, done at E3. Without the macro -> done at E33.
